// File: rtl/program_loader_if.sv
// Signal bundle between the boot image source, program_loader and the instruction memory.
interface program_loader_if;
  logic        start;
  logic [7:0]  len_words;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        checksum_err;

  modport master (
    output start, len_words, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, load_done, checksum_err
  );

  modport slave (
    input  start, len_words, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, load_done, checksum_err
  );
endinterface

// File: rtl/program_loader.sv
// Streams a byte-serial program image into instruction memory, one 32-bit word per write,
// holding the CPU in reset until done. Define LOADER_CHECKSUM_EN to add a trailing checksum byte.
module program_loader #(
  parameter int MEM_WORDS = 64
) (
  input logic            clk,
  input logic            reset,
  program_loader_if.slave bus
);
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam logic [7:0] MAX_WORDS = 8'(MEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    csum_add = acc + b;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  word_idx_q, word_idx_d;
  logic [7:0]  eff_len_q, eff_len_d;
  logic [7:0]  csum_q, csum_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] word_q, word_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_we_q, mem_we_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        load_done_q, load_done_d;
  logic        chk_err_q, chk_err_d;
  logic        byte_fire_s;
  state_e      last_state_s;
  logic [7:0]  start_len_s;

  assign byte_fire_s  = bus.in_valid && in_ready_q;
  assign last_state_s = CSUM_EN ? S_CHECK : S_DONE;
  assign start_len_s  = (bus.len_words > MAX_WORDS) ? MAX_WORDS : bus.len_words;

  // Next-state, word assembly and the registered-output values derived from the next state.
  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    eff_len_d   = eff_len_q;
    csum_d      = csum_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    chk_err_d   = chk_err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          eff_len_d  = start_len_s;
          word_idx_d = 8'd0;
          byte_idx_d = 2'd0;
          csum_d     = 8'd0;
          chk_err_d  = 1'b0;
          state_d    = (start_len_s == 8'd0) ? last_state_s : S_RECV;
        end else begin
          state_d = state_q;
        end
      end
      S_RECV: begin
        if (byte_fire_s) begin
          byte_idx_d = byte_idx_q + 2'd1;
          csum_d     = csum_add(csum_q, bus.in_data);
          // First byte of a word is the opcode and lands in the top byte lane.
          case (byte_idx_q)
            2'd0: word_d[23:16] = bus.in_data;
            2'd1: word_d[15:8]  = bus.in_data;
            2'd2: word_d[7:0]   = bus.in_data;
            default: begin
              state_d     = S_WRITE;
              mem_addr_d  = {22'd0, word_idx_q, 2'b00};
              mem_wdata_d = {word_q, bus.in_data};
            end
          endcase
        end else begin
          state_d = S_RECV;
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + 8'd1;
        if (word_idx_d == eff_len_q) begin
          state_d = last_state_s;
        end else begin
          state_d = S_RECV;
        end
      end
      S_CHECK: begin
        if (!CSUM_EN) begin
          state_d = S_IDLE;
        end else if (byte_fire_s) begin
          chk_err_d = (csum_add(csum_q, bus.in_data) != 8'd0);
          state_d   = S_DONE;
        end else begin
          state_d = S_CHECK;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_RECV) || (state_d == S_CHECK);
    mem_we_d    = (state_d == S_WRITE);
    load_done_d = (state_d == S_DONE);
    cpu_reset_d = !((state_d == S_DONE) && !chk_err_d);
  end

  // State and output registers; reset parks the loader in IDLE with the CPU held in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      word_idx_q  <= 8'd0;
      eff_len_q   <= 8'd0;
      csum_q      <= 8'd0;
      byte_idx_q  <= 2'd0;
      word_q      <= 24'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_reset_q <= 1'b1;
      load_done_q <= 1'b0;
      chk_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      eff_len_q   <= eff_len_d;
      csum_q      <= csum_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      cpu_reset_q <= cpu_reset_d;
      load_done_q <= load_done_d;
      chk_err_q   <= chk_err_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.cpu_reset    = cpu_reset_q;
  assign bus.load_done    = load_done_q;
  assign bus.checksum_err = chk_err_q;
endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a byte/word-level reference model predicts every output each
// cycle, plus directed loads with hand-computed literal results.
module tb_program_loader;
  localparam int MW = 64;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  program_loader_if bus();
  program_loader #(.MEM_WORDS(MW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t        log_q[$];
  logic [7:0] img[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] log_a(int i);
    return (i < log_q.size()) ? log_q[i].a : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] log_d(int i);
    return (i < log_q.size()) ? log_q[i].d : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] img_word(int w);
    return {img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]};
  endfunction
  function automatic logic [7:0] csum_ok();
    logic [7:0] s = 8'd0;
    foreach (img[i]) s = s + img[i];
    return 8'd0 - s;
  endfunction

  // ---------------- reference model: counts bytes and words of the current load ----------------
  bit          armed = 1'b0;
  bit          m_busy, m_csum, m_done, m_err;
  int          m_len, m_nbytes, m_words;
  logic [7:0]  m_sum;
  logic [7:0]  m_img[$];
  logic        exp_ready, exp_we, exp_done, exp_cpu_reset, exp_err;
  logic [31:0] exp_addr, exp_wdata;

  function automatic void m_finish();
    m_busy = 1'b0;
    if (CSUM) begin m_csum = 1'b1; exp_ready = 1'b1; end
    else begin m_done = 1'b1; exp_ready = 1'b0; end
  endfunction

  function automatic void model_step();
    logic fire, nwe;
    logic [7:0] d, t8;
    int n;
    fire = bus.in_valid && exp_ready;
    d    = bus.in_data;
    nwe  = 1'b0;
    if (reset) begin
      armed = 1'b1; m_busy = 1'b0; m_csum = 1'b0; m_done = 1'b0; m_err = 1'b0;
      exp_ready = 1'b0; exp_addr = 32'd0; exp_wdata = 32'd0;
    end else if (exp_we) begin
      m_words++;
      if (m_words == m_len) m_finish();
      else exp_ready = 1'b1;
    end else if (!m_busy && !m_csum && bus.start) begin
      m_len = (int'(bus.len_words) > MW) ? MW : int'(bus.len_words);
      m_nbytes = 0; m_words = 0; m_sum = 8'd0; m_err = 1'b0; m_done = 1'b0;
      m_img.delete();
      if (m_len == 0) m_finish();
      else begin m_busy = 1'b1; exp_ready = 1'b1; end
    end else if (fire && m_busy) begin
      m_img.push_back(d); m_sum = m_sum + d; m_nbytes++;
      if (m_nbytes % 4 == 0) begin
        n = m_nbytes;
        nwe = 1'b1; exp_ready = 1'b0;
        exp_addr  = 32'((n / 4 - 1) * 4);
        exp_wdata = {m_img[n-4], m_img[n-3], m_img[n-2], m_img[n-1]};
      end
    end else if (fire && m_csum) begin
      t8 = m_sum + d;
      m_err = (t8 != 8'd0); m_csum = 1'b0; m_done = 1'b1; exp_ready = 1'b0;
    end
    exp_we        = nwe;
    exp_done      = m_done;
    exp_err       = m_err;
    exp_cpu_reset = !(m_done && !m_err);
  endfunction

  // Per-cycle comparison against the model, mid-cycle, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    if (armed) begin
      check("in_ready", bus.in_ready, exp_ready);
      check("mem_we", bus.mem_we, exp_we);
      check("mem_addr", bus.mem_addr, exp_addr);
      check("mem_wdata", bus.mem_wdata, exp_wdata);
      check("load_done", bus.load_done, exp_done);
      check("cpu_reset", bus.cpu_reset, exp_cpu_reset);
      check("checksum_err", bus.checksum_err, exp_err);
      if (bus.mem_we === 1'b1) log_q.push_back({bus.mem_addr, bus.mem_wdata});
    end
    model_step();
  end

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    acc = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0; @(posedge clk); #1;
    end
    bus.in_valid = 1'b1; bus.in_data = b;
    for (int t = 0; t < 64; t++) begin
      acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    check("byte_accepted", acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] len);
    bus.start = 1'b1; bus.len_words = len;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.len_words = 8'($urandom);
  endtask

  task automatic pulse_reset();
    bus.in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send_image(input int nbytes, input int maxgap, input int pulse_pct);
    for (int i = 0; i < nbytes; i++) begin
      send_byte(img[i], $urandom_range(0, maxgap));
      if ((i % 4 != 3) && ($urandom_range(0, 99) < pulse_pct)) pulse_start(8'($urandom));
    end
  endtask

  task automatic finish_load(input logic [7:0] cbyte);
`ifdef LOADER_CHECKSUM_EN
    send_byte(cbyte, 0);
`else
    bus.in_data = cbyte;
`endif
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (bus.load_done !== 1'b1 && n < bound) begin
      @(posedge clk); #1; n++;
    end
    check("load_done_reached", bus.load_done, 1);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.len_words = 8'd0; bus.in_valid = 1'b0; bus.in_data = 8'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_cpu_reset", bus.cpu_reset, 1);
    check("rst_load_done", bus.load_done, 0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);

    // two-word image streamed back-to-back
    log_q.delete();
    pulse_start(8'd2);
    img = '{8'h55, 8'h89, 8'hE5, 8'h90, 8'h83, 8'hEC, 8'h08, 8'h90};
    send_image(8, 0, 0);
    finish_load(csum_ok());
    wait_done(20);
    check("b2b_nwrites", log_q.size(), 2);
    check("b2b_addr0", log_a(0), 32'h0000_0000);
    check("b2b_data0", log_d(0), 32'h5589_E590);
    check("b2b_addr1", log_a(1), 32'h0000_0004);
    check("b2b_data1", log_d(1), 32'h83EC_0890);
    check("model_last_wdata", exp_wdata, 32'h83EC_0890);
    check("b2b_cpu_reset", bus.cpu_reset, 0);

    // single word with gaps between bytes, restarted from DONE
    log_q.delete();
    pulse_start(8'd1);
    img = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_image(4, 2, 0);
    finish_load(csum_ok());
    wait_done(20);
    check("gap_nwrites", log_q.size(), 1);
    check("gap_data0", log_d(0), 32'h0102_0304);
    check("gap_addr0", log_a(0), 32'h0);

    // zero length: no writes, terminal phase one cycle after start
    log_q.delete();
    pulse_start(8'd0);
`ifdef LOADER_CHECKSUM_EN
    check("len0_check_ready", bus.in_ready, 1);
    img.delete();
    finish_load(8'h00);
`endif
    check("len0_done", bus.load_done, 1);
    check("len0_nwrites", log_q.size(), 0);

    // oversize length clamps to MEM_WORDS
    log_q.delete();
    img.delete();
    for (int i = 0; i < MW * 4; i++) img.push_back(8'($urandom));
    pulse_start(8'd200);
    send_image(MW * 4, 0, 0);
    finish_load(csum_ok());
    wait_done(20);
    check("clamp_nwrites", log_q.size(), MW);
    check("clamp_last_addr", log_a(MW - 1), 32'h0000_00FC);

    // reset after two bytes of word 1
    log_q.delete();
    img.delete();
    for (int i = 0; i < 6; i++) img.push_back(8'($urandom));
    pulse_start(8'd3);
    send_image(6, 0, 0);
    pulse_reset();
    check("rstmid_cpu_reset", bus.cpu_reset, 1);
    check("rstmid_in_ready", bus.in_ready, 0);
    repeat (4) @(posedge clk);
    #1;
    check("rstmid_nwrites", log_q.size(), 1);
    check("rstmid_word0", log_d(0), img_word(0));

    // start pulses during RECV are ignored
    log_q.delete();
    img.delete();
    for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
    pulse_start(8'd2);
    send_image(8, 1, 100);
    finish_load(csum_ok());
    wait_done(20);
    check("startign_nwrites", log_q.size(), 2);
    check("startign_w1", log_d(1), img_word(1));

`ifdef LOADER_CHECKSUM_EN
    img = '{8'h10, 8'h20, 8'h30, 8'h40};
    pulse_start(8'd1);
    send_image(4, 0, 0);
    finish_load(8'h60);
    wait_done(20);
    check("csum_good_err", bus.checksum_err, 0);
    check("csum_good_cpu_reset", bus.cpu_reset, 0);
    pulse_start(8'd1);
    send_image(4, 0, 0);
    finish_load(8'h61);
    wait_done(20);
    check("csum_bad_err", bus.checksum_err, 1);
    check("csum_bad_cpu_reset", bus.cpu_reset, 1);
`endif

    // randomized loads, some aborted by reset
    for (int it = 0; it < 24; it++) begin
      int len, eff, nb;
      bit abort;
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(65, 255) : $urandom_range(0, 40);
      eff = (len > MW) ? MW : len;
      img.delete();
      for (int i = 0; i < eff * 4; i++) img.push_back(8'($urandom));
      abort = (eff > 0) && ($urandom_range(0, 5) == 0);
      nb = abort ? $urandom_range(0, eff * 4 - 1) : eff * 4;
      log_q.delete();
      pulse_start(8'(len));
      send_image(nb, 2, 10);
      if (abort) begin
        pulse_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rnd_abort_nwrites", log_q.size(), nb / 4);
      end else begin
        finish_load(($urandom_range(0, 3) == 0) ? 8'($urandom) : csum_ok());
        wait_done(40);
        check("rnd_nwrites", log_q.size(), eff);
        for (int w = 0; w < eff; w++) begin
          check("rnd_addr", log_a(w), 32'(w * 4));
          check("rnd_data", log_d(w), img_word(w));
        end
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MEM_WORDS, default 64, SHALL give the instruction-memory depth in 32-bit words; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 start  input  1  single-cycle request to begin a load; SHALL be honoured only in IDLE or DONE.
REQ-005 len_words  input  8  word count of the image; SHALL be sampled on the cycle start is accepted.
REQ-006 in_valid  input  1  a byte is offered on in_data.
REQ-007 in_data  input  8  serial image byte.
REQ-008 in_ready  output  1  loader accepts in_data this cycle; a byte SHALL transfer when in_valid && in_ready.
REQ-009 mem_we  output  1  one-cycle write strobe to instruction memory.
REQ-010 mem_addr  output  32  byte address of the word written, equal to word_index*4.
REQ-011 mem_wdata  output  32  assembled instruction word.
REQ-012 cpu_reset  output  1  holds fetch/decode/register blocks in reset while high.
REQ-013 load_done  output  1  high while in DONE.
REQ-014 checksum_err  output  1  image checksum mismatch flag.

Function
REQ-015 States SHALL be IDLE, RECV, WRITE, CHECK, DONE.
REQ-016 IDLE: in_ready=0, mem_we=0, cpu_reset=1; accepted start SHALL move to RECV, clearing word_index, byte_index and checksum accumulator.
REQ-017 Effective length SHALL be min(len_words, MEM_WORDS); if 0, start SHALL move directly to DONE with no writes and no byte accepted.
REQ-018 RECV: in_ready=1; the k-th accepted byte of a word (k=0..3) SHALL be stored in bits [31-8k:24-8k], so the first byte (opcode) lands in [31:24].
REQ-019 Acceptance of byte k=3 SHALL move to WRITE on the next edge; in_ready SHALL be 0 in WRITE.
REQ-020 WRITE SHALL last exactly one cycle with mem_we=1, mem_addr=word_index*4 and mem_wdata equal to the assembled word.
REQ-021 After WRITE, word_index SHALL increment; if it equals the effective length, the next state SHALL be CHECK or DONE per REQ-030/031, otherwise RECV.
REQ-022 DONE: load_done=1, in_ready=0, cpu_reset=0 unless checksum_err=1; an accepted start SHALL restart per REQ-016 and reassert cpu_reset on the next edge.
REQ-023 in_valid while in_ready=0 SHALL be ignored, with no byte consumed.
REQ-024 start outside IDLE/DONE SHALL be ignored.
REQ-025 mem_we SHALL never be asserted outside WRITE; mem_addr and mem_wdata SHALL hold their last value otherwise.
REQ-026 The checksum accumulator SHALL be an 8-bit modulo-256 sum of every accepted byte.

Reset
REQ-027 On reset the block SHALL enter IDLE with in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, load_done=0 and checksum_err=0.
REQ-028 Reset mid-load SHALL discard any partial word, issue no further write, and leave previously written words untouched.
REQ-029 Reset SHALL take priority over start and over a byte transfer in the same cycle.

Configuration
REQ-030 With LOADER_CHECKSUM_EN defined:
- after the last WRITE the block SHALL enter CHECK with in_ready=1 and accept one checksum byte, then enter DONE;
- checksum_err SHALL be set if (accumulator + checksum byte) mod 256 != 0;
- when the effective length is 0, CHECK SHALL still accept one byte.
REQ-031 Without LOADER_CHECKSUM_EN:
- CHECK SHALL be unreachable and the last WRITE SHALL go directly to DONE;
- checksum_err SHALL be constant 0.

Verification
REQ-032 Reset, then start with len_words=2, then bytes 55 89 E5 90 83 EC 08 90 streamed back-to-back -> two writes: addr 0 data 5589E590, then addr 4 data 83EC0890; each mem_we exactly 1 cycle; load_done=1 and cpu_reset=0 afterwards.
REQ-033 in_valid toggled 1-0-1 with gaps, len_words=1, bytes 01 02 03 04 -> single write of 01020304 at addr 0; no byte lost or duplicated; in_ready=0 in the WRITE cycle.
REQ-034 len_words=0 -> DONE one cycle after start with mem_we never asserted; len_words=200 with MEM_WORDS=64 -> exactly 64 writes, last at addr 0xFC.
REQ-035 Reset asserted after 2 bytes of word 1 -> IDLE next cycle, cpu_reset=1, no write of the partial word; word 0 remains written.
REQ-036 LOADER_CHECKSUM_EN defined, len_words=1, bytes 10 20 30 40 then checksum byte 60 -> checksum_err=0 and cpu_reset=0; checksum byte 61 -> checksum_err=1 and cpu_reset stays 1.
REQ-037 start pulsed during RECV -> ignored; word_index and the byte sequence continue unchanged.
